// File: rtl/login_ctrl_pkg.sv
// Shared op/result codes, FSM states and default widths for the account-access
// controller that fronts the user-record SRAM.
package login_ctrl_pkg;

  localparam int ADDR_W_DEF    = 12;
  localparam int PASS_W_DEF    = 16;
  localparam int CNT_W_DEF     = 4;
  localparam int MAX_TRIES_DEF = 3;

  typedef enum logic [1:0] {
    OP_LOGIN    = 2'b00,
    OP_SET_PASS = 2'b01,
    OP_UNLOCK   = 2'b10,
    OP_RSVD     = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    RES_DENY      = 2'b00,
    RES_GRANT     = 2'b01,
    RES_LOCKED    = 2'b10,
    RES_NOT_ADMIN = 2'b11
  } res_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_CHK  = 3'd2,
    ST_WR   = 3'd3,
    ST_DONE = 3'd4
  } state_e;

endpackage

// File: rtl/login_ctrl_if.sv
// Command port (keypad/UI side) and record-SRAM port of the login controller.
// master drives the request/strobe side; slave is the responder.
interface login_cmd_if #(
  parameter int ADDR_W = login_ctrl_pkg::ADDR_W_DEF,
  parameter int PASS_W = login_ctrl_pkg::PASS_W_DEF
);
  logic              req;
  logic [1:0]        op;
  logic [ADDR_W-1:0] user_id;
  logic [PASS_W-1:0] pass_try;
  logic [PASS_W-1:0] new_pass;
  logic [ADDR_W-1:0] tgt_id;
  logic              busy;
  logic              done;
  logic [1:0]        res;
  logic              res_admin;

  modport master (
    output req, op, user_id, pass_try, new_pass, tgt_id,
    input  busy, done, res, res_admin
  );

  modport slave (
    input  req, op, user_id, pass_try, new_pass, tgt_id,
    output busy, done, res, res_admin
  );
endinterface

interface login_ram_if #(
  parameter int ADDR_W = login_ctrl_pkg::ADDR_W_DEF,
  parameter int PASS_W = login_ctrl_pkg::PASS_W_DEF,
  parameter int CNT_W  = login_ctrl_pkg::CNT_W_DEF
);
  logic              ram_cs;
  logic              ram_pass_rw;
  logic              ram_count_rw;
  logic              ram_admin_rw;
  logic              ram_lock_rw;
  logic [ADDR_W-1:0] ram_addr;
  logic [PASS_W-1:0] ram_pass_in;
  logic [CNT_W-1:0]  ram_count_in;
  logic              ram_admin_in;
  logic              ram_lock_in;
  logic [PASS_W-1:0] ram_pass_out;
  logic [CNT_W-1:0]  ram_count_out;
  logic              ram_admin_out;
  logic              ram_lock_out;

  modport master (
    output ram_cs, ram_pass_rw, ram_count_rw, ram_admin_rw, ram_lock_rw,
           ram_addr, ram_pass_in, ram_count_in, ram_admin_in, ram_lock_in,
    input  ram_pass_out, ram_count_out, ram_admin_out, ram_lock_out
  );

  modport slave (
    input  ram_cs, ram_pass_rw, ram_count_rw, ram_admin_rw, ram_lock_rw,
           ram_addr, ram_pass_in, ram_count_in, ram_admin_in, ram_lock_in,
    output ram_pass_out, ram_count_out, ram_admin_out, ram_lock_out
  );
endinterface

// File: rtl/login_ctrl.sv
// Login / set-password / unlock controller: one read-check-write pass over the
// user record per command, fixed latency, result code held until the next command.
//
// state   | meaning
// IDLE    | waiting for req, command fields latched on accept
// RD      | read caller record
// CHK     | compare password, capture count/admin/lock
// WR      | write back the fields this outcome changes (if any)
// DONE    | one-cycle done pulse, result valid
module login_ctrl
  import login_ctrl_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int PASS_W    = PASS_W_DEF,
  parameter int CNT_W     = CNT_W_DEF,
  parameter int MAX_TRIES = MAX_TRIES_DEF
) (
  input  logic        clk,
  input  logic        rst,
  login_cmd_if.slave  cmd,
  login_ram_if.master ram
);

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] TRIES_LIM = CNT_W'(MAX_TRIES);

  state_e state, state_nxt;

  op_e               op_q;
  logic [ADDR_W-1:0] user_q;
  logic [ADDR_W-1:0] tgt_q;
  logic [PASS_W-1:0] pass_q;
  logic [PASS_W-1:0] new_q;
  logic              match_q;
  logic              admin_q;
  logic              lock_q;
  logic [CNT_W-1:0]  cnt_q;
  res_e              res_q;
  logic              res_admin_q;

  logic              accept;
  logic [CNT_W-1:0]  fail_cnt;
  logic              fail_lock;
  logic              caller_ok;
  logic              wr_pass;
  logic              wr_cnt;
  logic              wr_lock;
  logic              wr_at_tgt;
  logic              lock_val;
  logic [CNT_W-1:0]  cnt_val;
  res_e              res_nxt;

  assign accept    = (state == ST_IDLE) && cmd.req;
  assign fail_cnt  = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + 1'b1;
  assign fail_lock = (fail_cnt >= TRIES_LIM);
  assign caller_ok = match_q && !lock_q;

  // Outcome of the checked record; every failure path shares the LOGIN rules.
  always_comb begin
    wr_pass   = 1'b0;
    wr_cnt    = 1'b0;
    wr_lock   = 1'b0;
    wr_at_tgt = 1'b0;
    lock_val  = 1'b0;
    cnt_val   = '0;
    res_nxt   = RES_DENY;
    if (op_q == OP_SET_PASS && caller_ok) begin
      wr_pass = 1'b1;
      wr_cnt  = 1'b1;
      res_nxt = RES_GRANT;
    end else if (op_q == OP_UNLOCK && caller_ok) begin
      if (admin_q) begin
        wr_cnt    = 1'b1;
        wr_lock   = 1'b1;
        wr_at_tgt = 1'b1;
        res_nxt   = RES_GRANT;
      end else begin
        res_nxt = RES_NOT_ADMIN;
      end
    end else if (lock_q) begin
      res_nxt = RES_LOCKED;
    end else if (match_q) begin
      // only a plain LOGIN can reach here with a good, unlocked caller
      wr_cnt  = 1'b1;
      res_nxt = RES_GRANT;
    end else begin
      wr_cnt  = 1'b1;
      cnt_val = fail_cnt;
      if (fail_lock) begin
        wr_lock  = 1'b1;
        lock_val = 1'b1;
        res_nxt  = RES_LOCKED;
      end else begin
        res_nxt = RES_DENY;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (cmd.req) state_nxt = (op_e'(cmd.op) == OP_RSVD) ? ST_DONE : ST_RD;
      ST_RD:   state_nxt = ST_CHK;
      ST_CHK:  state_nxt = ST_WR;
      ST_WR:   state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd.busy         = (state != ST_IDLE);
    cmd.done         = (state == ST_DONE);
    ram.ram_cs       = 1'b0;
    ram.ram_pass_rw  = 1'b0;
    ram.ram_count_rw = 1'b0;
    ram.ram_admin_rw = 1'b0;
    ram.ram_lock_rw  = 1'b0;
    ram.ram_addr     = '0;
    ram.ram_pass_in  = '0;
    ram.ram_count_in = '0;
    ram.ram_admin_in = 1'b0;
    ram.ram_lock_in  = 1'b0;
    case (state)
      ST_RD: begin
        ram.ram_cs   = 1'b1;
        ram.ram_addr = user_q;
      end
      ST_WR: begin
        if (wr_pass || wr_cnt || wr_lock) begin
          ram.ram_cs       = 1'b1;
          ram.ram_pass_rw  = wr_pass;
          ram.ram_count_rw = wr_cnt;
          ram.ram_lock_rw  = wr_lock;
          ram.ram_addr     = wr_at_tgt ? tgt_q : user_q;
          ram.ram_pass_in  = wr_pass ? new_q : '0;
          ram.ram_count_in = cnt_val;
          ram.ram_lock_in  = lock_val;
        end
      end
      default: ;
    endcase
  end

  assign cmd.res       = res_q;
  assign cmd.res_admin = res_admin_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q        <= OP_LOGIN;
      user_q      <= '0;
      tgt_q       <= '0;
      pass_q      <= '0;
      new_q       <= '0;
      match_q     <= 1'b0;
      admin_q     <= 1'b0;
      lock_q      <= 1'b0;
      cnt_q       <= '0;
      res_q       <= RES_DENY;
      res_admin_q <= 1'b0;
    end else begin
      if (accept) begin
        op_q        <= op_e'(cmd.op);
        user_q      <= cmd.user_id;
        tgt_q       <= cmd.tgt_id;
        pass_q      <= cmd.pass_try;
        new_q       <= cmd.new_pass;
        res_q       <= RES_DENY;
        res_admin_q <= 1'b0;
      end
      if (state == ST_CHK) begin
        match_q <= (ram.ram_pass_out == pass_q);
        cnt_q   <= ram.ram_count_out;
        admin_q <= ram.ram_admin_out;
        lock_q  <= ram.ram_lock_out;
      end
      if (state == ST_WR) begin
        res_q       <= res_nxt;
        res_admin_q <= admin_q;
      end
    end
  end

endmodule
